// File: rtl/serial_sample_receiver_pkg.sv
// Shared definitions for the sine-sample serial receive path.
// Holds the default widths and the receiver state encoding.
package serial_sample_receiver_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned BCNT_W_DEF = 6;
   localparam int unsigned WCNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_WAIT_LD = 2'd2,
      ST_DRAIN   = 2'd3
   } rx_state_e;

endpackage

// File: rtl/serial_sample_receiver_if.sv
// Serial frame inputs and valid/ready word output of the sample receiver.
// slave = receiver side, master = link driver / word consumer side.
interface serial_sample_receiver_if
   import serial_sample_receiver_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              SI;
   logic              bit_en;
   logic              CS_n;
   logic              LD_n;
   logic [DATA_W-1:0] d_out;
   logic              d_valid;
   logic              d_ready;

   modport slave (
      input  SI, bit_en, CS_n, LD_n, d_ready,
      output d_out, d_valid
   );

   modport master (
      output SI, bit_en, CS_n, LD_n, d_ready,
      input  d_out, d_valid
   );

endinterface

// File: rtl/serial_shift_in.sv
// MSB-first deserialiser: shift register plus count of bits taken since clr.
// clr and shift in the same cycle start a new word with SI as its first bit.
module serial_shift_in
   import serial_sample_receiver_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned BCNT_W = BCNT_W_DEF
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              clr,
   input  logic              shift,
   input  logic              SI,
   output logic [DATA_W-1:0] q,
   output logic [BCNT_W-1:0] cnt
);

   logic [DATA_W-1:0] q_d, q_q;
   logic [BCNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      if (clr) begin
         q_d   = '0;
         cnt_d = '0;
      end
      if (shift) begin
         q_d   = {q_d[DATA_W-2:0], SI};
         cnt_d = cnt_d + BCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!RST) begin
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q   = q_q;
   assign cnt = cnt_q;

endmodule

// File: rtl/serial_sample_receiver.sv
// Receive end of the sine-sample serial link: frames SI into DATA_W-bit words,
// flags malformed frames and hold-register overruns, counts accepted words.
module serial_sample_receiver
   import serial_sample_receiver_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned BCNT_W = BCNT_W_DEF,
   parameter int unsigned WCNT_W = WCNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  RST,
   serial_sample_receiver_if.slave bus,
   output logic                  frame_err,
   output logic                  overrun,
   output logic [WCNT_W-1:0]     word_cnt
);

   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

   rx_state_e         state_d, state_q;
   logic [DATA_W-1:0] d_out_d, d_out_q;
   logic              d_valid_d, d_valid_q;
   logic              frame_err_d, frame_err_q;
   logic              overrun_d, overrun_q;
   logic [WCNT_W-1:0] word_cnt_d, word_cnt_q;

   logic              sr_clr_c;
   logic              sr_shift_c;
   logic              bad_frame_c;
   logic              word_done_c;
   logic [DATA_W-1:0] sr_q;
   logic [BCNT_W-1:0] sr_cnt;

   serial_shift_in #(
      .DATA_W (DATA_W),
      .BCNT_W (BCNT_W)
   ) u_shift_in (
      .clk   (clk),
      .RST   (RST),
      .clr   (sr_clr_c),
      .shift (sr_shift_c),
      .SI    (bus.SI),
      .q     (sr_q),
      .cnt   (sr_cnt)
   );

   // Frame sequencing: decides when bits are taken and how each frame ends.
   always_comb begin
      state_d     = state_q;
      sr_clr_c    = 1'b0;
      sr_shift_c  = 1'b0;
      bad_frame_c = 1'b0;
      word_done_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!bus.CS_n) begin
               state_d    = ST_SHIFT;
               sr_clr_c   = 1'b1;
               sr_shift_c = bus.bit_en;
            end
         end
         ST_SHIFT: begin
            if (bus.CS_n) begin
               bad_frame_c = 1'b1;
               state_d     = ST_IDLE;
            end else if (!bus.LD_n) begin
               bad_frame_c = 1'b1;
               state_d     = ST_DRAIN;
            end else if (bus.bit_en) begin
               sr_shift_c = 1'b1;
               if (sr_cnt == LAST_BIT) state_d = ST_WAIT_LD;
            end
         end
         ST_WAIT_LD: begin
            // An extra bit outranks a simultaneous load strobe.
            if (bus.bit_en) begin
               bad_frame_c = 1'b1;
               state_d     = bus.CS_n ? ST_IDLE : ST_DRAIN;
            end else if (!bus.LD_n) begin
               word_done_c = 1'b1;
               state_d     = bus.CS_n ? ST_IDLE : ST_DRAIN;
            end else if (bus.CS_n) begin
               bad_frame_c = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (bus.CS_n) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Hold register, pulse flags and accepted-word counter.
   always_comb begin
      d_out_d     = d_out_q;
      d_valid_d   = d_valid_q;
      word_cnt_d  = word_cnt_q;
      overrun_d   = 1'b0;
      frame_err_d = bad_frame_c;
      if (word_done_c) begin
         if (!d_valid_q || bus.d_ready) begin
            d_out_d    = sr_q;
            d_valid_d  = 1'b1;
            word_cnt_d = word_cnt_q + WCNT_W'(1);
         end else begin
            overrun_d = 1'b1;
         end
      end else if (d_valid_q && bus.d_ready) begin
         d_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         d_out_q     <= '0;
         d_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         d_out_q     <= d_out_d;
         d_valid_q   <= d_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign bus.d_out   = d_out_q;
   assign bus.d_valid = d_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun     = overrun_q;
   assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_serial_sample_receiver.sv
// Bench for serial_sample_receiver: directed frame table, mid-frame reset and
// random frames checked against a frame-level model of the hold register.
module tb_serial_sample_receiver;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam int          CNT_MOD = 16;

   logic          clk;
   logic          RST;
   logic          frame_err;
   logic          overrun;
   logic [CW-1:0] word_cnt;

   serial_sample_receiver_if #(.DATA_W(DW)) bus ();

   serial_sample_receiver #(
      .DATA_W (DW),
      .BCNT_W (6),
      .WCNT_W (CW)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .bus       (bus),
      .frame_err (frame_err),
      .overrun   (overrun),
      .word_cnt  (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   int ovr_pulses = 0;
   int err_base;
   int ovr_base;

   // Frame-level model state
   logic [DW-1:0] m_dout;
   bit            m_valid;
   int            m_cnt;
   bit            m_ovr;

   typedef struct {
      logic [DW-1:0] data;
      int            kind;   // 0 good, 1 CS early, 2 LD early, 3 extra bit
      int            nbits;
      int            gap;
      bit            rb;     // d_ready during bits
      bit            rl;     // d_ready on LD / end cycle
      bit            ra;     // d_ready on the cycle after
      logic [DW-1:0] e_dout;
      bit            e_valid;
      int            e_cnt;
      int            e_err;
      int            e_ovr;
   } vec_t;

   vec_t vecs[9];

   always @(negedge clk) begin
      if (frame_err === 1'b1) err_pulses++;
      if (overrun === 1'b1) ovr_pulses++;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic ld, input logic be, input logic si, input logic rdy);
      bus.CS_n    = cs;
      bus.LD_n    = ld;
      bus.bit_en  = be;
      bus.SI      = si;
      bus.d_ready = rdy;
   endtask

   task automatic run_frame(input logic [DW-1:0] data, input int kind, input int nbits,
                            input int gap, input bit rb, input bit rl, input bit ra);
      logic b;
      err_base = err_pulses;
      ovr_base = ovr_pulses;
      m_ovr    = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         for (int j = 0; j < gap; j++) begin
            b = (i < 32) ? data[31-i] : 1'b1;
            drive(1'b0, 1'b1, j == 0, b, rb);
            tick();
         end
      end
      if (rb) m_valid = 1'b0;
      if (kind == 1) drive(1'b1, 1'b1, 1'b0, 1'b0, rl);
      else           drive(1'b0, 1'b0, 1'b0, 1'b0, rl);
      tick();
      if (kind == 0) begin
         if (!m_valid || rl) begin
            m_dout  = data;
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1) % CNT_MOD;
         end else begin
            m_ovr = 1'b1;
         end
         check("lat_valid", 32'(bus.d_valid), 32'(1));
         check("lat_dout", bus.d_out, m_dout);
         check("lat_ovr", 32'(overrun), 32'(m_ovr));
         check("lat_cnt", 32'(word_cnt), 32'(m_cnt));
      end else if (rl) begin
         m_valid = 1'b0;
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, ra);
      tick();
      if (ra) m_valid = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic check_frame(input string tag, input logic [DW-1:0] ed, input bit ev,
                              input int ec, input int ee, input int eo);
      check({tag, "_dout"}, bus.d_out, ed);
      check({tag, "_valid"}, 32'(bus.d_valid), 32'(ev));
      check({tag, "_cnt"}, 32'(word_cnt), 32'(ec));
      check({tag, "_err"}, 32'(err_pulses - err_base), 32'(ee));
      check({tag, "_ovr"}, 32'(ovr_pulses - ovr_base), 32'(eo));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_dout"}, bus.d_out, 32'h0);
      check({tag, "_valid"}, 32'(bus.d_valid), 32'(0));
      check({tag, "_cnt"}, 32'(word_cnt), 32'(0));
      check({tag, "_ferr"}, 32'(frame_err), 32'(0));
      check({tag, "_ovr"}, 32'(overrun), 32'(0));
   endtask

   initial begin
      int kind;
      int nb;

      vecs[0] = '{32'h1234_5678, 1, 20, 1, 0, 0, 0, 32'h0,         0, 0, 1, 0};
      vecs[1] = '{32'h7FFF_0000, 0, 32, 4, 0, 0, 0, 32'h7FFF_0000, 1, 1, 0, 0};
      vecs[2] = '{32'hA5A5_A5A5, 0, 32, 1, 1, 0, 0, 32'hA5A5_A5A5, 1, 2, 0, 0};
      vecs[3] = '{32'h0000_FFFF, 0, 32, 2, 0, 0, 0, 32'hA5A5_A5A5, 1, 2, 0, 1};
      vecs[4] = '{32'h1357_9BDF, 0, 32, 1, 0, 1, 0, 32'h1357_9BDF, 1, 3, 0, 0};
      vecs[5] = '{32'hDEAD_BEEF, 3, 33, 1, 0, 0, 1, 32'h1357_9BDF, 0, 3, 1, 0};
      vecs[6] = '{32'hCAFE_F00D, 0, 32, 2, 0, 0, 0, 32'hCAFE_F00D, 1, 4, 0, 0};
      vecs[7] = '{32'h0F0F_0F0F, 2, 16, 1, 0, 0, 1, 32'hCAFE_F00D, 0, 4, 1, 0};
      vecs[8] = '{32'h8000_0001, 0, 32, 3, 0, 0, 1, 32'h8000_0001, 0, 5, 0, 0};

      RST = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check_zero("rst");
      RST = 1'b1;
      tick();
      m_dout  = '0;
      m_valid = 1'b0;
      m_cnt   = 0;

      foreach (vecs[k]) begin
         run_frame(vecs[k].data, vecs[k].kind, vecs[k].nbits, vecs[k].gap,
                   vecs[k].rb, vecs[k].rl, vecs[k].ra);
         check_frame($sformatf("vec%0d", k), vecs[k].e_dout, vecs[k].e_valid,
                     vecs[k].e_cnt, vecs[k].e_err, vecs[k].e_ovr);
      end

      // Reset after 10 bits of a frame, then a clean frame
      err_base = err_pulses;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'(i % 2), 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      tick();
      tick();
      check_zero("midrst");
      RST = 1'b1;
      tick();
      check("midrst_noerr", 32'(err_pulses - err_base), 32'(0));
      m_dout  = '0;
      m_valid = 1'b0;
      m_cnt   = 0;
      run_frame(32'h3C3C_5AA5, 0, 32, 1, 0, 0, 0);
      check_frame("postrst", 32'h3C3C_5AA5, 1, 1, 0, 0);

      for (int r = 0; r < 60; r++) begin
         kind = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
         case (kind)
            1:       nb = int'($urandom_range(1, 32));
            2:       nb = int'($urandom_range(1, 31));
            3:       nb = 33;
            default: nb = 32;
         endcase
         run_frame($urandom, kind, nb, int'($urandom_range(1, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom));
         check_frame($sformatf("rnd%0d", r), m_dout, m_valid, m_cnt,
                     (kind != 0) ? 1 : 0, m_ovr ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
